aud_recorder: RTL
=================

AUD_RECORDER -- requirements
Module: aud_recorder

Interface
REQ-001 The block SHALL have port i_bclk, input, 1 bit: codec bit clock, the only clock; all logic on its rising edge.
REQ-002 The block SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port i_lrc, input, 1 bit: ADC left/right clock from the codec; low = left channel.
REQ-004 The block SHALL have port i_data, input, 1 bit: ADC serial data from the codec, MSB first.
REQ-005 The block SHALL have ports i_start, i_pause, i_stop, input, 1 bit each: level-sampled control from the top FSM.
REQ-006 The block SHALL have port o_address, output, 20 bits: SRAM word address of the current or next sample.
REQ-007 The block SHALL have port o_data, output, 16 bits: last captured left-channel sample.
REQ-008 The block SHALL have port o_valid, output, 1 bit: one-cycle write strobe qualifying o_data and o_address.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-010 The block SHALL implement states IDLE, WAIT_EDGE, CAPTURE, WRITE and PAUSED.
REQ-011 The block SHALL register i_lrc into prev_lrc every cycle in all states, and SHALL define a falling edge as prev_lrc=1 and i_lrc=0.
REQ-012 In IDLE with i_start=1, the block SHALL clear o_address to 0 and enter WAIT_EDGE on the next cycle.
REQ-013 In WAIT_EDGE on a falling edge, the block SHALL enter CAPTURE with bit counter 0; the edge cycle SHALL be the I2S one-bit delay, and i_data SHALL NOT be sampled in that cycle.
REQ-014 In CAPTURE, the block SHALL shift i_data into the LSB of a 16-bit shift register and increment the bit counter each cycle, for exactly 16 cycles, then enter WRITE.
REQ-015 The first captured bit SHALL land in o_data[15]; the right channel and any bits beyond 16 SHALL be ignored.
REQ-016 In WRITE, the block SHALL drive o_data with the assembled sample and assert o_valid for exactly that one cycle, with o_address unchanged.
REQ-017 On leaving WRITE, the block SHALL increment o_address by 1 if it is below 20'hFFFFF.
REQ-018 On leaving WRITE with o_address = 20'hFFFFF, the block SHALL hold o_address and enter IDLE (memory full; recording ends).
REQ-019 Otherwise, on leaving WRITE, the block SHALL go to PAUSED if a pause is pending and to WAIT_EDGE if not.
REQ-020 i_pause in WAIT_EDGE SHALL move the block to PAUSED on the next cycle.
REQ-021 i_pause in CAPTURE or WRITE SHALL set a pending flag that is honoured after WRITE, so the in-flight sample completes; the flag SHALL clear on entry to PAUSED.
REQ-022 In PAUSED with i_start=1, the block SHALL enter WAIT_EDGE with o_address preserved (resume); i_pause in PAUSED SHALL have no effect.
REQ-023 i_stop in any non-IDLE state SHALL force IDLE on the next cycle, discard any partial sample, suppress o_valid that cycle, clear the pending pause, and keep o_address unchanged.
REQ-024 Simultaneous controls SHALL be prioritised stop > pause > start; i_start outside IDLE and PAUSED SHALL be ignored.
REQ-025 o_data SHALL hold its value between WRITE cycles.
REQ-026 A falling i_lrc edge arriving during CAPTURE or WRITE SHALL be ignored (no restart).

Reset
REQ-027 While i_rst_n=0, the block SHALL set state=IDLE, o_address=0, o_data=0, o_valid=0, o_busy=0, shift register=0, bit counter=0, prev_lrc=0 and pending pause=0, all asynchronously.
REQ-028 Reset asserted mid-capture SHALL abort the capture with no o_valid pulse; after release, the block SHALL stay in IDLE until i_start.

Verification
REQ-029 Start, then an LRC falling edge followed by serial 16'hA5C3 MSB-first after the one-bit delay -> o_valid pulses once with o_data=16'hA5C3 and o_address=0; o_address=1 on the next cycle.
REQ-030 Three consecutive frames with left 16'h0001, 16'h8000, 16'hFFFF and right channel 16'h1234 -> exactly three o_valid pulses at addresses 0, 1, 2 with those values; 16'h1234 is never written.
REQ-031 i_pause at the 8th CAPTURE bit -> the sample still completes (one o_valid), the block enters PAUSED, o_address=1; a later i_start resumes and the next write is at address 1.
REQ-032 i_stop at the 10th CAPTURE bit -> IDLE next cycle, no o_valid, o_busy=0; a new i_start restarts with the first write at address 0.
REQ-033 o_address preloaded to 20'hFFFFF via a long run, then one more sample -> o_valid at 20'hFFFFF, then IDLE with o_address held at 20'hFFFFF.
REQ-034 i_rst_n pulsed low mid-CAPTURE -> all outputs zero immediately, no o_valid after release, and i_start/i_pause/i_stop asserted together in IDLE -> block stays IDLE.

Source files
------------

// File: rtl/aud_recorder.sv
// I2S left-channel capture: assembles 16-bit samples and streams them to SRAM.
// Supports start, pause (finishes the in-flight sample) and stop (discards it).
module aud_recorder (
    input  logic        i_bclk,
    input  logic        i_rst_n,
    input  logic        i_lrc,
    input  logic        i_data,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_stop,
    output logic [19:0] o_address,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_CAP,
        S_WRITE,
        S_PAUSE
    } state_t;

    localparam logic [19:0] ADDR_MAX = 20'hFFFFF;

    state_t      state_q, state_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        prev_lrc_q;
    logic        fall;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        o_valid = 1'b0;
        fall    = prev_lrc_q & ~i_lrc;

        unique case (state_q)
            S_IDLE: begin
                if (i_start && !i_pause && !i_stop) begin
                    addr_d  = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_pause) begin
                    state_d = S_PAUSE;
                end else if (fall) begin
                    // Edge cycle is the I2S one-bit delay; data is not sampled.
                    state_d = S_CAP;
                    cnt_d   = '0;
                end
            end
            S_CAP: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    shift_d = {shift_q[14:0], i_data};
                    cnt_d   = cnt_q + 4'd1;
                    if (i_pause) pend_d = 1'b1;
                    if (cnt_q == 4'd15) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    o_valid = 1'b1;
                    data_d  = shift_q;
                    if (addr_q == ADDR_MAX) begin
                        state_d = S_IDLE;
                        pend_d  = 1'b0;
                    end else begin
                        addr_d = addr_q + 20'd1;
                        if (pend_q || i_pause) begin
                            state_d = S_PAUSE;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_PAUSE: begin
                if (i_stop) begin
                    state_d = S_IDLE;
                end else if (i_start && !i_pause) begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            prev_lrc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            prev_lrc_q <= i_lrc;
        end
    end

    // During the write cycle the fresh sample bypasses the holding register.
    assign o_data    = o_valid ? shift_q : data_q;
    assign o_address = addr_q;
    assign o_busy    = (state_q != S_IDLE);

endmodule
